// File: rtl/io_pkg.sv
// Shared I/O subsystem constants: word addresses (addr[7:2]) of the input and output
// port blocks, plus the read-select decode for the input block.
package io_pkg;

  localparam int unsigned IO_NPORTS = 3;

  localparam logic [5:0] IO_IN0_A  = 6'b110000;  // C0h
  localparam logic [5:0] IO_IN1_A  = 6'b110001;  // C4h
  localparam logic [5:0] IO_IN2_A  = 6'b110010;  // C8h
  localparam logic [5:0] IO_EDGE_A = 6'b110011;  // CCh

  localparam logic [5:0] IO_OUT0_A = 6'b100000;  // 80h
  localparam logic [5:0] IO_OUT1_A = 6'b100001;  // 84h
  localparam logic [5:0] IO_OUT2_A = 6'b101010;  // A8h

  typedef enum logic [2:0] {
    RD_NONE,
    RD_IN0,
    RD_IN1,
    RD_IN2,
    RD_EDGE
  } rd_sel_e;

  function automatic rd_sel_e decode_rd(input logic [5:0] word_addr);
    case (word_addr)
      IO_IN0_A:  return RD_IN0;
      IO_IN1_A:  return RD_IN1;
      IO_IN2_A:  return RD_IN2;
      IO_EDGE_A: return RD_EDGE;
      default:   return RD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-port debouncer: accepts a new synchronised bus value only after it has
// differed from the accepted value for DEB_CYCLES consecutive cycles.
module io_debounce #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] filt
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any cycle where the input matches the accepted value restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= '0;
    end else if (sync != filt) begin
      if (cnt == LAST) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/io_input_sync.sv
// Memory-mapped input-port block: synchronises three input buses, captures rising edges
// of port 0 into clear-on-read flags, returns registered read data. Option: IO_DEBOUNCE_EN.
module io_input_sync
  import io_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             read_io_enable,
  input  logic [WIDTH-1:0] in_port0,
  input  logic [WIDTH-1:0] in_port1,
  input  logic [WIDTH-1:0] in_port2,
  output logic [WIDTH-1:0] dataout
);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("io_input_sync: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
  end

  logic [WIDTH-1:0] in_bus [IO_NPORTS];
  logic [WIDTH-1:0] sync   [IO_NPORTS];
  logic [WIDTH-1:0] filt   [IO_NPORTS];

  assign in_bus[0] = in_port0;
  assign in_bus[1] = in_port1;
  assign in_bus[2] = in_port2;

  for (genvar p = 0; p < IO_NPORTS; p++) begin : g_port
    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge io_clk) begin
      if (reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) chain[s] <= '0;
      end else begin
        chain[0] <= in_bus[p];
        for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
      end
    end

    assign sync[p] = chain[SYNC_STAGES-1];

`ifdef IO_DEBOUNCE_EN
    io_debounce #(
      .WIDTH      (WIDTH),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
      .clk   (io_clk),
      .reset (reset),
      .sync  (sync[p]),
      .filt  (filt[p])
    );
`else
    assign filt[p] = sync[p];
`endif
  end

  logic [WIDTH-1:0] prev0;
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] rd_val_c;
  logic             rd_edge_c;
  logic             unused_addr;

  assign unused_addr = ^{addr[31:8], addr[1:0]};
  assign rise_c      = filt[0] & ~prev0;

  // Read mux; a strobed read of the flag word clears exactly the bits it returns.
  always_comb begin
    rd_val_c  = '0;
    rd_edge_c = 1'b0;
    case (decode_rd(addr[7:2]))
      RD_IN0:  rd_val_c = filt[0];
      RD_IN1:  rd_val_c = filt[1];
      RD_IN2:  rd_val_c = filt[2];
      RD_EDGE: begin
        rd_val_c  = edge_flags;
        rd_edge_c = read_io_enable;
      end
      default: rd_val_c = '0;
    endcase
  end

  // New edges are ORed in after the clear, so a same-cycle edge survives the read.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      prev0      <= '0;
      edge_flags <= '0;
      dataout    <= '0;
    end else begin
      prev0      <= filt[0];
      edge_flags <= (rd_edge_c ? '0 : edge_flags) | rise_c;
      if (read_io_enable) dataout <= rd_val_c;
    end
  end

endmodule
